// File: rtl/mul3_rr_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mul3_rr_sched                                              |
// | Description : Round-robin scheduler in front of one shared 3x3 unsigned  |
// |               multiplier. Each requester has a valid/ready operand port; |
// |               results leave on one valid/ready port tagged with the ID   |
// |               of the requester, after LAT (1 or 2) register stages.      |
// | Ports       : clk, rst          clock / synchronous active-high reset    |
// |               req_valid_i       per-requester operand valid            |
// |               req_a_i/req_b_i   packed 3-bit operands, slice i = [3i+:3] |
// |               req_ready_o       one-hot (or zero) acceptance             |
// |               resp_valid_o/resp_ready_i  result handshake                |
// |               resp_id_o/resp_z_o          winner ID and product          |
// |               busy_o            any pipeline stage holds a valid entry   |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module mul3_rr_sched #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2,
  parameter int LAT   = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid_i,
  input  logic [3*N_REQ-1:0] req_a_i,
  input  logic [3*N_REQ-1:0] req_b_i,
  output logic [N_REQ-1:0]   req_ready_o,
  output logic               resp_valid_o,
  input  logic               resp_ready_i,
  output logic [ID_W-1:0]    resp_id_o,
  output logic [5:0]         resp_z_o,
  output logic               busy_o
);

  // One extra bit so ptr+k can be compared against N_REQ before wrapping.
  localparam int IW = ID_W + 1;

  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic             valid1_q;
  logic [ID_W-1:0]  id1_q;
  logic [5:0]       z1_q;

  logic             w_adv;
  logic             w_found;
  logic [ID_W-1:0]  w_win;
  logic [N_REQ-1:0] w_grant;
  logic             w_xfer;
  logic [2:0]       w_a;
  logic [2:0]       w_b;
  logic [5:0]       w_z;

  // Whole-pipe stall: nothing moves while a result sits unaccepted.
  assign w_adv = !resp_valid_o | resp_ready_i;

  // Round-robin search starting at ptr, wrapping past N_REQ-1.
  always_comb begin
    logic [IW-1:0] idx;
    w_found = 1'b0;
    w_win   = '0;
    idx     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = {1'b0, ptr_q} + IW'(k);
      if (idx >= IW'(N_REQ)) idx = idx - IW'(N_REQ);
      if (!w_found && req_valid_i[idx[ID_W-1:0]]) begin
        w_found = 1'b1;
        w_win   = idx[ID_W-1:0];
      end
    end
  end

  assign w_grant     = w_found ? (N_REQ'(1) << w_win) : '0;
  assign req_ready_o = w_grant & {N_REQ{w_adv & !rst}};
  assign w_xfer      = |req_ready_o;

  // Operand mux driven by the one-hot grant, then the shared multiplier.
  always_comb begin
    w_a = '0;
    w_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_grant[i]) begin
        w_a = req_a_i[3*i +: 3];
        w_b = req_b_i[3*i +: 3];
      end
    end
  end

  assign w_z = {3'b000, w_a} * {3'b000, w_b};

  always_comb begin
    ptr_d = ptr_q;
    if (w_xfer) begin
      if (w_win == ID_W'(N_REQ - 1)) ptr_d = '0;
      else                           ptr_d = w_win + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q    <= '0;
      valid1_q <= 1'b0;
      id1_q    <= '0;
      z1_q     <= '0;
    end else begin
      ptr_q <= ptr_d;
      if (w_adv) begin
        valid1_q <= w_xfer;
        if (w_xfer) begin
          id1_q <= w_win;
          z1_q  <= w_z;
        end
      end
    end
  end

  generate
    if (LAT == 2) begin : g_lat2
      logic            valid2_q;
      logic [ID_W-1:0] id2_q;
      logic [5:0]      z2_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          valid2_q <= 1'b0;
          id2_q    <= '0;
          z2_q     <= '0;
        end else if (w_adv) begin
          valid2_q <= valid1_q;
          id2_q    <= id1_q;
          z2_q     <= z1_q;
        end
      end

      assign resp_valid_o = valid2_q;
      assign resp_id_o    = id2_q;
      assign resp_z_o     = z2_q;
      assign busy_o       = valid1_q | valid2_q;
    end else begin : g_lat1
      assign resp_valid_o = valid1_q;
      assign resp_id_o    = id1_q;
      assign resp_z_o     = z1_q;
      assign busy_o       = valid1_q;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_mul3_rr_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_mul3_rr_sched                                           |
// | Description : Directed self-checking bench; u_dut1 is built with LAT=1,  |
// |               u_dut2 with LAT=2, both N_REQ=4.                           |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_mul3_rr_sched;

  logic        clk;
  int          total;
  int          bad;

  // LAT=1 instance signals
  logic        rst1;
  logic [3:0]  rv1;
  logic [11:0] ra1, rb1;
  logic [3:0]  rr1;
  logic        vo1, rdy1, busy1;
  logic [1:0]  id1;
  logic [5:0]  z1;

  // LAT=2 instance signals
  logic        rst2;
  logic [3:0]  rv2;
  logic [11:0] ra2, rb2;
  logic [3:0]  rr2;
  logic        vo2, rdy2, busy2;
  logic [1:0]  id2;
  logic [5:0]  z2;

  mul3_rr_sched #(.N_REQ(4), .ID_W(2), .LAT(1)) u_dut1 (
    .clk(clk), .rst(rst1), .req_valid_i(rv1), .req_a_i(ra1), .req_b_i(rb1),
    .req_ready_o(rr1), .resp_valid_o(vo1), .resp_ready_i(rdy1),
    .resp_id_o(id1), .resp_z_o(z1), .busy_o(busy1)
  );

  mul3_rr_sched #(.N_REQ(4), .ID_W(2), .LAT(2)) u_dut2 (
    .clk(clk), .rst(rst2), .req_valid_i(rv2), .req_a_i(ra2), .req_b_i(rb2),
    .req_ready_o(rr2), .resp_valid_o(vo2), .resp_ready_i(rdy2),
    .resp_id_o(id2), .resp_z_o(z2), .busy_o(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst1 = 1'b1; rst2 = 1'b1;
    rv1 = 4'hF;  rv2 = 4'hF;
    ra1 = 12'o7777; rb1 = 12'o7777; ra2 = 12'o7777; rb2 = 12'o7777;
    rdy1 = 1'b1; rdy2 = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++; if (rr1 !== 4'b0000) begin bad++; $display("FAIL reset_ready1 cyc=%0d got=%b exp=0000", c, rr1); end
      total++; if (rr2 !== 4'b0000) begin bad++; $display("FAIL reset_ready2 cyc=%0d got=%b exp=0000", c, rr2); end
      tick();
    end
    rst1 = 1'b0; rst2 = 1'b0;
    rv1 = 4'h0;  rv2 = 4'h0;
    #1;
    total++; if (vo1 !== 1'b0 || busy1 !== 1'b0) begin bad++; $display("FAIL reset_out1 got vo=%b busy=%b exp 0 0", vo1, busy1); end
    total++; if (id1 !== 2'd0 || z1 !== 6'd0) begin bad++; $display("FAIL reset_data1 got id=%0d z=%0d exp 0 0", id1, z1); end
    total++; if (vo2 !== 1'b0 || busy2 !== 1'b0) begin bad++; $display("FAIL reset_out2 got vo=%b busy=%b exp 0 0", vo2, busy2); end
    total++; if (id2 !== 2'd0 || z2 !== 6'd0) begin bad++; $display("FAIL reset_data2 got id=%0d z=%0d exp 0 0", id2, z2); end
    tick();
    total++; if (vo1 !== 1'b0 || busy1 !== 1'b0) begin bad++; $display("FAIL reset_idle1 got vo=%b busy=%b exp 0 0", vo1, busy1); end
  endtask

  task automatic test_single();
    // requester 2: a=5, b=6
    ra1 = {3'd0, 3'd5, 3'd0, 3'd0};
    rb1 = {3'd0, 3'd6, 3'd0, 3'd0};
    rv1 = 4'b0100;
    #1;
    total++; if (rr1 !== 4'b0100) begin bad++; $display("FAIL single_ready got=%b exp=0100", rr1); end
    tick();
    rv1 = 4'b0000;
    total++; if (vo1 !== 1'b1 || busy1 !== 1'b1) begin bad++; $display("FAIL single_valid got vo=%b busy=%b exp 1 1", vo1, busy1); end
    total++; if (id1 !== 2'd2) begin bad++; $display("FAIL single_id got=%0d exp=2", id1); end
    total++; if (z1 !== 6'd30) begin bad++; $display("FAIL single_z got=%0d exp=30", z1); end
    tick();
    total++; if (vo1 !== 1'b0 || busy1 !== 1'b0) begin bad++; $display("FAIL single_drain got vo=%b busy=%b exp 0 0", vo1, busy1); end
  endtask

  task automatic test_round_robin();
    logic [5:0] exp_z [4];
    exp_z[0] = 6'd2; exp_z[1] = 6'd6; exp_z[2] = 6'd12; exp_z[3] = 6'd20;
    // Return the pointer to 0 so the order starts at requester 0.
    rst1 = 1'b1;
    tick();
    rst1 = 1'b0;
    // requester i: a=i+1, b=i+2
    ra1 = {3'd4, 3'd3, 3'd2, 3'd1};
    rb1 = {3'd5, 3'd4, 3'd3, 3'd2};
    rv1 = 4'hF;
    rdy1 = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1;
      total++; if (rr1 !== (4'b0001 << (c % 4))) begin bad++; $display("FAIL rr_grant cyc=%0d got=%b exp=%b", c, rr1, 4'b0001 << (c % 4)); end
      tick();
      total++; if (vo1 !== 1'b1 || id1 !== 2'(c % 4)) begin bad++; $display("FAIL rr_resp cyc=%0d got vo=%b id=%0d exp vo=1 id=%0d", c, vo1, id1, c % 4); end
      total++; if (z1 !== exp_z[c % 4]) begin bad++; $display("FAIL rr_z cyc=%0d got=%0d exp=%0d", c, z1, exp_z[c % 4]); end
    end
    rv1 = 4'h0;
    tick();
    total++; if (vo1 !== 1'b0) begin bad++; $display("FAIL rr_drain got vo=%b exp=0", vo1); end
  endtask

  task automatic test_backpressure();
    // pointer is 0; only requester 1 valid with a=7, b=7
    ra1 = {3'd1, 3'd3, 3'd7, 3'd1};
    rb1 = {3'd1, 3'd3, 3'd7, 3'd1};
    rv1 = 4'b0010;
    rdy1 = 1'b0;
    #1;
    total++; if (rr1 !== 4'b0010) begin bad++; $display("FAIL bp_first_grant got=%b exp=0010", rr1); end
    tick();
    rv1 = 4'hF;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++; if (rr1 !== 4'b0000) begin bad++; $display("FAIL bp_ready cyc=%0d got=%b exp=0000", c, rr1); end
      total++; if (vo1 !== 1'b1 || id1 !== 2'd1 || z1 !== 6'd49) begin bad++; $display("FAIL bp_hold cyc=%0d got vo=%b id=%0d z=%0d exp vo=1 id=1 z=49", c, vo1, id1, z1); end
      tick();
    end
    rdy1 = 1'b1;
    #1;
    // pointer sits at 2 after the grant to requester 1
    total++; if (rr1 !== 4'b0100) begin bad++; $display("FAIL bp_resume_grant got=%b exp=0100", rr1); end
    tick();
    rv1 = 4'h0;
    total++; if (vo1 !== 1'b1 || id1 !== 2'd2 || z1 !== 6'd9) begin bad++; $display("FAIL bp_resume_resp got vo=%b id=%0d z=%0d exp vo=1 id=2 z=9", vo1, id1, z1); end
    tick();
    total++; if (vo1 !== 1'b0) begin bad++; $display("FAIL bp_drain got vo=%b exp=0", vo1); end
  endtask

  task automatic test_exhaustive_lat1();
    logic [5:0] exp;
    rdy1 = 1'b1;
    for (int n = 0; n < 64; n++) begin
      ra1 = {3'd0, 3'd0, 3'(n / 8), 3'd0};
      rb1 = {3'd0, 3'd0, 3'(n % 8), 3'd0};
      rv1 = 4'b0010;
      #1;
      total++; if (rr1 !== 4'b0010) begin bad++; $display("FAIL ex1_grant n=%0d got=%b exp=0010", n, rr1); end
      tick();
      exp = 6'((n / 8) * (n % 8));
      total++; if (vo1 !== 1'b1 || id1 !== 2'd1 || z1 !== exp) begin bad++; $display("FAIL ex1_resp a=%0d b=%0d got vo=%b id=%0d z=%0d exp vo=1 id=1 z=%0d", n / 8, n % 8, vo1, id1, z1, exp); end
    end
    rv1 = 4'h0;
    tick();
  endtask

  task automatic test_exhaustive_lat2();
    logic [5:0] exp;
    rdy2 = 1'b1;
    for (int n = 0; n < 66; n++) begin
      if (n < 64) begin
        ra2 = {3'd0, 3'd0, 3'(n / 8), 3'd0};
        rb2 = {3'd0, 3'd0, 3'(n % 8), 3'd0};
        rv2 = 4'b0010;
      end else begin
        rv2 = 4'b0000;
      end
      tick();
      if (n == 0) begin
        total++; if (vo2 !== 1'b0 || busy2 !== 1'b1) begin bad++; $display("FAIL ex2_latency got vo=%b busy=%b exp vo=0 busy=1", vo2, busy2); end
      end else if (n <= 64) begin
        exp = 6'(((n - 1) / 8) * ((n - 1) % 8));
        total++; if (vo2 !== 1'b1 || id2 !== 2'd1 || z2 !== exp) begin bad++; $display("FAIL ex2_resp a=%0d b=%0d got vo=%b id=%0d z=%0d exp vo=1 id=1 z=%0d", (n - 1) / 8, (n - 1) % 8, vo2, id2, z2, exp); end
      end else begin
        total++; if (vo2 !== 1'b0 || busy2 !== 1'b0) begin bad++; $display("FAIL ex2_drain got vo=%b busy=%b exp 0 0", vo2, busy2); end
      end
    end
  endtask

  task automatic test_reset_midflight();
    // Two entries: req 1 (7*7) then req 2 (3*3), pointer starts at 2.
    ra2 = {3'd0, 3'd3, 3'd7, 3'd0};
    rb2 = {3'd0, 3'd3, 3'd7, 3'd0};
    rdy2 = 1'b0;
    rv2 = 4'b0010;
    tick();
    rv2 = 4'b0100;
    tick();
    rv2 = 4'b0000;
    total++; if (busy2 !== 1'b1) begin bad++; $display("FAIL mf_inflight got busy=%b exp=1", busy2); end
    rst2 = 1'b1;
    tick();
    rst2 = 1'b0;
    rdy2 = 1'b1;
    total++; if (vo2 !== 1'b0 || busy2 !== 1'b0 || id2 !== 2'd0 || z2 !== 6'd0) begin bad++; $display("FAIL mf_flushed got vo=%b busy=%b id=%0d z=%0d exp 0 0 0 0", vo2, busy2, id2, z2); end
    ra2 = {3'd1, 3'd1, 3'd1, 3'd2};
    rb2 = {3'd1, 3'd1, 3'd1, 3'd5};
    rv2 = 4'hF;
    #1;
    total++; if (rr2 !== 4'b0001) begin bad++; $display("FAIL mf_ptr_grant got=%b exp=0001", rr2); end
    tick();
    rv2 = 4'h0;
    total++; if (vo2 !== 1'b0) begin bad++; $display("FAIL mf_no_stale got vo=%b exp=0", vo2); end
    tick();
    total++; if (vo2 !== 1'b1 || id2 !== 2'd0 || z2 !== 6'd10) begin bad++; $display("FAIL mf_new_resp got vo=%b id=%0d z=%0d exp vo=1 id=0 z=10", vo2, id2, z2); end
    tick();
    total++; if (vo2 !== 1'b0 || busy2 !== 1'b0) begin bad++; $display("FAIL mf_idle got vo=%b busy=%b exp 0 0", vo2, busy2); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_exhaustive_lat1();
    test_exhaustive_lat2();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
